id_ex_stage: RTL

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/id_ex_pkg.sv | 22 ++
 rtl/id_ex_stage_hazard_detect.sv | 22 ++
 rtl/id_ex_stage.sv | 111 +++++++++++
 3 files changed

// File: rtl/id_ex_pkg.sv
// Shared definitions for the ID/EX pipeline stage: control-bundle bit map,
// bubble constant and the immediate sign-extension helper.
package id_ex_pkg;

  localparam int CTRL_W         = 10;

  localparam int CTRL_REGWRITE  = 0;
  localparam int CTRL_MEMREAD   = 1;
  localparam int CTRL_MEMWRITE  = 2;
  localparam int CTRL_MEMTOREG  = 3;
  localparam int CTRL_ALUSRC    = 4;
  localparam int CTRL_REGDST    = 5;
  localparam int CTRL_ALUOP_LSB = 6;
  localparam int CTRL_ALUOP_MSB = 9;

  localparam logic [CTRL_W-1:0] CTRL_BUBBLE = '0;

  function automatic logic [31:0] sign_ext16(input logic [15:0] value);
    return {{16{value[15]}}, value};
  endfunction

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard detection: a valid load in EX whose destination feeds an
// operand of the instruction in ID forces a one-cycle stall.
module hazard_detect (
  input  logic       valid_ex,
  input  logic       mem_read_ex,
  input  logic [4:0] rt_ex,
  input  logic [4:0] rs_id,
  input  logic [4:0] rt_id,
  input  logic       valid_in,
  input  logic       flush,
  output logic       stall
);

  logic hazard;

  assign hazard = valid_ex && mem_read_ex && (rt_ex != 5'd0) &&
                  ((rt_ex == rs_id) || (rt_ex == rt_id));

  // A flushed ID instruction is discarded anyway, so it never needs to wait.
  assign stall = hazard && valid_in && !flush;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline stage: register-file addressing, WB bypass, load-use stall,
// bubble insertion on flush/stall and a saturating stall counter.
module id_ex_stage
  import id_ex_pkg::*;
#(
  parameter int CTRL_W = id_ex_pkg::CTRL_W
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [31:0]       Instruction,
  input  logic [31:0]       PCPlus4,
  input  logic              ValidIn,
  input  logic [CTRL_W-1:0] ControlIn,
  input  logic              Flush,
  output logic [4:0]        ReadRegister1,
  output logic [4:0]        ReadRegister2,
  input  logic [31:0]       ReadData1,
  input  logic [31:0]       ReadData2,
  input  logic              RegWrite_WB,
  input  logic [4:0]        WriteRegister_WB,
  input  logic [31:0]       WriteData_WB,
  output logic              Stall,
  output logic [31:0]       RD1_EX,
  output logic [31:0]       RD2_EX,
  output logic [31:0]       Imm_EX,
  output logic [31:0]       PCPlus4_EX,
  output logic [4:0]        Rs_EX,
  output logic [4:0]        Rt_EX,
  output logic [4:0]        Rd_EX,
  output logic [CTRL_W-1:0] Ctrl_EX,
  output logic              Valid_EX,
  output logic [15:0]       StallCount
);

  logic        stall;
  logic [31:0] operand1;
  logic [31:0] operand2;
  logic        unused_opcode;

  assign ReadRegister1 = Instruction[25:21];
  assign ReadRegister2 = Instruction[20:16];
  assign unused_opcode = ^Instruction[31:26];

  hazard_detect u_hazard (
    .valid_ex    (Valid_EX),
    .mem_read_ex (Ctrl_EX[CTRL_MEMREAD]),
    .rt_ex       (Rt_EX),
    .rs_id       (ReadRegister1),
    .rt_id       (ReadRegister2),
    .valid_in    (ValidIn),
    .flush       (Flush),
    .stall       (stall)
  );

  assign Stall = stall;

  // WB writes in the same cycle the register file is read, so the file
  // returns the stale value; forward the write data instead.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    operand1 = ReadData1;
    operand2 = ReadData2;
    if (RegWrite_WB && (WriteRegister_WB != 5'd0) && (WriteRegister_WB == ReadRegister1))
      operand1 = WriteData_WB;
    if (RegWrite_WB && (WriteRegister_WB != 5'd0) && (WriteRegister_WB == ReadRegister2))
      operand2 = WriteData_WB;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      RD1_EX     <= '0;
      RD2_EX     <= '0;
      Imm_EX     <= '0;
      PCPlus4_EX <= '0;
      Rs_EX      <= '0;
      Rt_EX      <= '0;
      Rd_EX      <= '0;
      Ctrl_EX    <= CTRL_W'(CTRL_BUBBLE);
      Valid_EX   <= 1'b0;
    end else if (Flush || stall) begin
      RD1_EX     <= '0;
      RD2_EX     <= '0;
      Imm_EX     <= '0;
      PCPlus4_EX <= '0;
      Rs_EX      <= '0;
      Rt_EX      <= '0;
      Rd_EX      <= '0;
      Ctrl_EX    <= CTRL_W'(CTRL_BUBBLE);
      Valid_EX   <= 1'b0;
    end else begin
      RD1_EX     <= operand1;
      RD2_EX     <= operand2;
      Imm_EX     <= sign_ext16(Instruction[15:0]);
      PCPlus4_EX <= PCPlus4;
      Rs_EX      <= ReadRegister1;
      Rt_EX      <= ReadRegister2;
      Rd_EX      <= Instruction[15:11];
      Ctrl_EX    <= ValidIn ? ControlIn : CTRL_W'(CTRL_BUBBLE);
      Valid_EX   <= ValidIn;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst)
      StallCount <= '0;
    else if (stall && (StallCount != 16'hFFFF))
      StallCount <= StallCount + 16'd1;
  end

endmodule
